// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned RegIdxW  = 4;
  localparam int unsigned WaitCntW = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW comparator between ID sources and EX/MEM destinations.
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic               forward_en,
  input  logic [RegIdxW-1:0] src1_id,
  input  logic [RegIdxW-1:0] src2_id,
  input  logic               use_rn_id,
  input  logic               use_src2_id,
  input  logic [RegIdxW-1:0] exe_dest,
  input  logic               exe_wb_en,
  input  logic               exe_mem_read,
  input  logic [RegIdxW-1:0] mem_dest,
  input  logic               mem_wb_en,
  output logic               hazard_raw
);

  logic exe_match;
  logic mem_match;

  always_comb begin
    exe_match = (use_rn_id & (src1_id == exe_dest)) | (use_src2_id & (src2_id == exe_dest));
    mem_match = (use_rn_id & (src1_id == mem_dest)) | (use_src2_id & (src2_id == mem_dest));
  end

  // With forwarding only a load in EX cannot be bypassed in time.
  always_comb begin
    if (forward_en) begin
      hazard_raw = exe_mem_read & exe_match;
    end else begin
      hazard_raw = (exe_wb_en & exe_match) | (mem_wb_en & mem_match);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: RAW stalls, branch flushes, SRAM wait-state freeze
// and saturating stall/flush statistics.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               forward_en,
  input  logic [RegIdxW-1:0] src1_id,
  input  logic [RegIdxW-1:0] src2_id,
  input  logic               use_rn_id,
  input  logic               use_src2_id,
  input  logic [RegIdxW-1:0] exe_dest,
  input  logic               exe_wb_en,
  input  logic               exe_mem_read,
  input  logic [RegIdxW-1:0] mem_dest,
  input  logic               mem_wb_en,
  input  logic               mem_access,
  input  logic               b_exe,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_clr,
  output logic               idex_en,
  output logic               idex_clr,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               sram_start,
  output logic               sram_done,
  output logic               hazard,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  ctrl_state_e         state_q, state_d;
  logic [WaitCntW-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                hazard_raw;
  logic                freeze;
  logic                start_acc;
  logic                last_acc;

  pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
    .forward_en   (forward_en),
    .src1_id      (src1_id),
    .src2_id      (src2_id),
    .use_rn_id    (use_rn_id),
    .use_src2_id  (use_src2_id),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_read (exe_mem_read),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard_raw   (hazard_raw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    start_acc = (state_q == StIdle) & mem_access;
    last_acc  = (state_q == StBusy) & (wcnt_q == '0);
    freeze    = start_acc | ((state_q == StBusy) & (wcnt_q != '0));
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_access) begin
          state_d = StBusy;
          wcnt_d  = WaitCntW'(MEM_WAIT - 1);
        end
      end
      StBusy: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WaitCntW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        wcnt_d  = '0;
      end
    endcase
  end

  // Priority: freeze > branch flush > RAW stall > free-run; all quiet in reset.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_clr   = 1'b0;
    idex_en    = 1'b0;
    idex_clr   = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    hazard     = 1'b0;
    sram_start = 1'b0;
    sram_done  = 1'b0;
    if (!rst) begin
      sram_start = start_acc;
      sram_done  = last_acc;
      hazard     = hazard_raw & ~freeze & ~b_exe;
      if (!freeze) begin
        pc_en    = ~hazard;
        ifid_en  = ~hazard;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        ifid_clr = b_exe;
        idex_clr = b_exe | hazard;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((freeze | hazard) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((b_exe & ~freeze) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_WAIT=4, CNT_W=16).
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        forward_en;
  logic [3:0]  src1_id;
  logic [3:0]  src2_id;
  logic        use_rn_id;
  logic        use_src2_id;
  logic [3:0]  exe_dest;
  logic        exe_wb_en;
  logic        exe_mem_read;
  logic [3:0]  mem_dest;
  logic        mem_wb_en;
  logic        mem_access;
  logic        b_exe;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_clr;
  logic        idex_en;
  logic        idex_clr;
  logic        exmem_en;
  logic        memwb_en;
  logic        sram_start;
  logic        sram_done;
  logic        hazard;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks;
  int failures;

  // {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en, sram_start, sram_done, hazard}
  logic [9:0] outs;
  assign outs = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en,
                 sram_start, sram_done, hazard};

  localparam logic [9:0] OutZero   = 10'b0000000000;
  localparam logic [9:0] OutRun    = 10'b1101011000;
  localparam logic [9:0] OutStall  = 10'b0001111001;
  localparam logic [9:0] OutStart  = 10'b0000000100;
  localparam logic [9:0] OutDone   = 10'b1101011010;
  localparam logic [9:0] OutDoneBr = 10'b1111111010;
  localparam logic [9:0] OutFlush  = 10'b1111111000;

  pipeline_hazard_ctrl #(
    .MEM_WAIT (4),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .forward_en   (forward_en),
    .src1_id      (src1_id),
    .src2_id      (src2_id),
    .use_rn_id    (use_rn_id),
    .use_src2_id  (use_src2_id),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_read (exe_mem_read),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_access   (mem_access),
    .b_exe        (b_exe),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_clr     (ifid_clr),
    .idex_en      (idex_en),
    .idex_clr     (idex_clr),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .sram_start   (sram_start),
    .sram_done    (sram_done),
    .hazard       (hazard),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    forward_en   = 1'b0;
    src1_id      = 4'd0;
    src2_id      = 4'd0;
    use_rn_id    = 1'b0;
    use_src2_id  = 1'b0;
    exe_dest     = 4'd0;
    exe_wb_en    = 1'b0;
    exe_mem_read = 1'b0;
    mem_dest     = 4'd0;
    mem_wb_en    = 1'b0;
    mem_access   = 1'b0;
    b_exe        = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    mem_access = 1'b1;
    b_exe      = 1'b1;
    rst        = 1'b1;
    #1;
    checks++;
    if (outs !== OutZero) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=%b", outs, OutZero);
    end
    tick();
    checks++;
    if (outs !== OutZero) begin
      failures++;
      $display("FAIL reset_outs_held got=%b exp=%b", outs, OutZero);
    end
    checks++;
    if ({stall_cnt, flush_cnt} !== 32'h0) begin
      failures++;
      $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt);
    end
    clear_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== OutRun) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", outs, OutRun);
    end
  endtask

  task automatic test_raw_noforward();
    do_reset();
    exe_wb_en = 1'b1;
    exe_dest  = 4'd3;
    src1_id   = 4'd3;
    use_rn_id = 1'b1;
    #1;
    checks++;
    if (outs !== OutStall) begin
      failures++;
      $display("FAIL raw_exe_src1 got=%b exp=%b", outs, OutStall);
    end
    tick();
    use_rn_id = 1'b0;
    #1;
    checks++;
    if (outs !== OutRun) begin
      failures++;
      $display("FAIL raw_unused_src1 got=%b exp=%b", outs, OutRun);
    end
    // MEM-stage match on PC index 15 via src2
    exe_wb_en   = 1'b0;
    mem_wb_en   = 1'b1;
    mem_dest    = 4'd15;
    src2_id     = 4'd15;
    use_src2_id = 1'b1;
    #1;
    checks++;
    if (outs !== OutStall) begin
      failures++;
      $display("FAIL raw_mem_r15 got=%b exp=%b", outs, OutStall);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd2) begin
      failures++;
      $display("FAIL raw_stall_cnt got=%0d exp=2", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    forward_en   = 1'b1;
    exe_mem_read = 1'b1;
    exe_wb_en    = 1'b1;
    exe_dest     = 4'd5;
    src2_id      = 4'd5;
    use_src2_id  = 1'b1;
    #1;
    checks++;
    if (outs !== OutStall) begin
      failures++;
      $display("FAIL load_use got=%b exp=%b", outs, OutStall);
    end
    tick();
    exe_mem_read = 1'b0;
    #1;
    checks++;
    if (outs !== OutRun) begin
      failures++;
      $display("FAIL fwd_no_load got=%b exp=%b", outs, OutRun);
    end
    exe_wb_en = 1'b0;
    mem_wb_en = 1'b1;
    mem_dest  = 4'd5;
    #1;
    checks++;
    if (outs !== OutRun) begin
      failures++;
      $display("FAIL fwd_mem_match got=%b exp=%b", outs, OutRun);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt);
    end
  endtask

  task automatic test_mem_access();
    do_reset();
    mem_access = 1'b1;
    #1;
    checks++;
    if (outs !== OutStart) begin
      failures++;
      $display("FAIL acc_cycle0 got=%b exp=%b", outs, OutStart);
    end
    for (int c = 1; c < 4; c++) begin
      tick();
      checks++;
      if (outs !== OutZero) begin
        failures++;
        $display("FAIL acc_cycle%0d got=%b exp=%b", c, outs, OutZero);
      end
    end
    tick();
    checks++;
    if (outs !== OutDone) begin
      failures++;
      $display("FAIL acc_done got=%b exp=%b", outs, OutDone);
    end
    tick();
    mem_access = 1'b0;
    #1;
    checks++;
    if (outs !== OutRun) begin
      failures++;
      $display("FAIL acc_after got=%b exp=%b", outs, OutRun);
    end
    checks++;
    if (stall_cnt !== 16'd4) begin
      failures++;
      $display("FAIL acc_stall_cnt got=%0d exp=4", stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_access = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (outs !== OutStart) begin
      failures++;
      $display("FAIL b2b_restart got=%b exp=%b", outs, OutStart);
    end
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (outs !== OutDone) begin
      failures++;
      $display("FAIL b2b_done got=%b exp=%b", outs, OutDone);
    end
    tick();
    mem_access = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 16'd8) begin
      failures++;
      $display("FAIL b2b_stall_cnt got=%0d exp=8", stall_cnt);
    end
  endtask

  task automatic test_branch_in_freeze();
    do_reset();
    mem_access = 1'b1;
    b_exe      = 1'b1;
    #1;
    checks++;
    if (outs !== OutStart) begin
      failures++;
      $display("FAIL brf_cycle0 got=%b exp=%b", outs, OutStart);
    end
    for (int c = 1; c < 4; c++) begin
      tick();
      checks++;
      if (outs !== OutZero) begin
        failures++;
        $display("FAIL brf_cycle%0d got=%b exp=%b", c, outs, OutZero);
      end
    end
    tick();
    checks++;
    if (outs !== OutDoneBr) begin
      failures++;
      $display("FAIL brf_done got=%b exp=%b", outs, OutDoneBr);
    end
    tick();
    mem_access = 1'b0;
    b_exe      = 1'b0;
    #1;
    checks++;
    if ({stall_cnt, flush_cnt} !== {16'd4, 16'd1}) begin
      failures++;
      $display("FAIL brf_cnts got=%0d/%0d exp=4/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    exe_wb_en = 1'b1;
    exe_dest  = 4'd7;
    src1_id   = 4'd7;
    use_rn_id = 1'b1;
    b_exe     = 1'b1;
    #1;
    checks++;
    if (outs !== OutFlush) begin
      failures++;
      $display("FAIL br_over_haz got=%b exp=%b", outs, OutFlush);
    end
    tick();
    b_exe = 1'b0;
    use_rn_id = 1'b0;
    #1;
    checks++;
    if ({stall_cnt, flush_cnt} !== {16'd0, 16'd1}) begin
      failures++;
      $display("FAIL br_cnts got=%0d/%0d exp=0/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_reset_mid_access();
    logic seen_done;
    do_reset();
    mem_access = 1'b1;
    tick();
    tick();
    checks++;
    if (stall_cnt !== 16'd2) begin
      failures++;
      $display("FAIL mid_pre_cnt got=%0d exp=2", stall_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({outs, stall_cnt} !== {OutZero, 16'd0}) begin
      failures++;
      $display("FAIL mid_rst_outs got=%b/%0d exp=%b/0", outs, stall_cnt, OutZero);
    end
    tick();
    mem_access = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== OutRun) begin
      failures++;
      $display("FAIL mid_after_rst got=%b exp=%b", outs, OutRun);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (sram_done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_done got=%b exp=0", seen_done);
    end
    mem_access = 1'b1;
    #1;
    checks++;
    if (outs !== OutStart) begin
      failures++;
      $display("FAIL mid_idle_restart got=%b exp=%b", outs, OutStart);
    end
    mem_access = 1'b0;
    #1;
  endtask

  task automatic test_saturation();
    do_reset();
    // Freeze covers 4 of every 5 cycles; the exposed RAW stall covers the 5th.
    mem_access = 1'b1;
    exe_wb_en  = 1'b1;
    exe_dest   = 4'd2;
    src1_id    = 4'd2;
    use_rn_id  = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (stall_cnt !== 16'd10) begin
      failures++;
      $display("FAIL sat_early got=%0d exp=10", stall_cnt);
    end
    for (int c = 10; c < 65540; c++) tick();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_stall_cnt got=%h exp=ffff", stall_cnt);
    end
    clear_inputs();
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_raw_noforward();
    test_load_use();
    test_mem_access();
    test_back_to_back();
    test_branch_in_freeze();
    test_branch_priority();
    test_reset_mid_access();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. Generates the en/clr controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three sources:
- RAW hazard detection between ID sources and EX/MEM destinations (forwarding-aware).
- Branch-taken flush from EX.
- A wait-state FSM that freezes the whole pipeline while the multi-cycle data SRAM services a MEM-stage access.
It also keeps saturating stall and flush statistics counters.

Parameters:
MEM_WAIT, 4, freeze cycles per SRAM access (legal range 1..15)
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
forward_en  in  1  forwarding unit enabled
src1_id  in  4  Rn index of the instruction in ID
src2_id  in  4  Rm/Rd index of the instruction in ID
use_rn_id  in  1  ID instruction reads src1
use_src2_id  in  1  ID instruction reads src2 (register-operand or STR)
exe_dest  in  4  destination register in EX
exe_wb_en  in  1  EX instruction writes back
exe_mem_read  in  1  EX instruction is a load
mem_dest  in  4  destination register in MEM
mem_wb_en  in  1  MEM instruction writes back
mem_access  in  1  MEM instruction reads or writes the SRAM
b_exe  in  1  branch taken, resolved in EX
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register enable
ifid_clr  out  1  IF/ID synchronous clear
idex_en  out  1  ID/EX register enable
idex_clr  out  1  ID/EX clear (bubble insert)
exmem_en  out  1  EX/MEM register enable
memwb_en  out  1  MEM/WB register enable
sram_start  out  1  one-cycle pulse: SRAM access begins
sram_done  out  1  one-cycle pulse: last cycle of access, pipeline advances
hazard  out  1  RAW stall active this cycle
stall_cnt  out  CNT_W  cycles with hazard or freeze asserted
flush_cnt  out  CNT_W  branch flushes taken

Behaviour:
- Reset (rst=1, asynchronous):
  - FSM goes to IDLE, wait counter to 0, stall_cnt and flush_cnt to 0.
  - While rst is high, all enables, all clears, sram_start, sram_done and hazard are 0.
- FSM states are IDLE and BUSY.
  - IDLE & mem_access: go to BUSY, load wcnt=MEM_WAIT-1, pulse sram_start.
  - BUSY & wcnt!=0: decrement wcnt.
  - BUSY & wcnt==0: pulse sram_done, return to IDLE.
- freeze = (IDLE & mem_access) | (BUSY & wcnt!=0).
  - An access therefore freezes for exactly MEM_WAIT cycles and completes on the (MEM_WAIT+1)th cycle.
- RAW detection:
  - m1 = use_rn_id & (src1_id==D).
  - m2 = use_src2_id & (src2_id==D).
- hazard, when forward_en=0: (exe_wb_en & match(exe_dest)) | (mem_wb_en & match(mem_dest)).
- hazard, when forward_en=1: exe_mem_read & match(exe_dest), i.e. load-use only.
- hazard is masked to 0 while freeze=1 or b_exe=1.
- Output priority, highest first:
  - freeze: all five enables 0, all clears 0. Branch and hazard actions are deferred, because EX contents are held.
  - b_exe: all enables 1, ifid_clr=1, idex_clr=1.
  - hazard: pc_en=0, ifid_en=0, idex_clr=1, other enables 1.
  - otherwise: all enables 1, clears 0.
- Outputs are combinational from the FSM state and the inputs. No added latency.
- Back-to-back accesses: the cycle after sram_done, a new mem_access in IDLE restarts the freeze immediately.
- A branch coinciding with an access: the flush is applied on the sram_done cycle.
- Counters update on the clock edge and saturate at all-ones:
  - stall_cnt +1 when (freeze | hazard).
  - flush_cnt +1 when b_exe & ~freeze.
- Reset mid-access aborts the access: no sram_done pulse, FSM returns to IDLE.
- Register index 15 (PC) is treated like any other register. No special case.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, BUSY=1).
  - Register-index width constant (4).
- One natural sub-module, hazard_detect: purely combinational RAW comparator producing hazard.
- The FSM, output priority mux and counters stay in pipeline_hazard_ctrl.

Test Plan:
- forward_en=0, exe_wb_en=1, exe_dest=3, src1_id=3, use_rn_id=1 -> hazard=1, pc_en=0, ifid_en=0, idex_clr=1. Repeat with use_rn_id=0 -> hazard=0.
- forward_en=1, exe_mem_read=1, exe_dest=5, src2_id=5, use_src2_id=1 -> one stall cycle. Same with exe_mem_read=0 -> no stall.
- MEM_WAIT=4, mem_access held high for one access -> sram_start at cycle 0, all enables 0 for cycles 0-3, sram_done and enables 1 at cycle 4, stall_cnt=4.
- b_exe=1 during the freeze of an access -> no clears during the freeze; ifid_clr=idex_clr=1 on the sram_done cycle; flush_cnt=1.
- b_exe=1 together with hazard conditions -> flush wins, hazard=0, pc_en=1.
- rst pulse at freeze cycle 2 -> outputs 0 while rst is high; IDLE and counters 0 afterwards; no sram_done; stall_cnt saturates at 16'hFFFF under forced long stall.
